rgb_frame_writer: RTL and testbench

//  Downstream stage of the CTE colour-transform engine. Captures every 24-bit RGB word from the CTE

---
 rtl/rgb_frame_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_rgb_frame_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer: buffers CTE output words in a small FIFO and drains them
// to a single-port frame memory at raster addresses 0..FRAME_PIXELS-1.
// The CTE cannot be stalled, so memory back-pressure is absorbed here and any
// lost word raises a sticky overflow flag.
// Optional feature: define CHECKSUM_EN to add a 24-bit XOR checksum output of
// all words accepted by the memory since reset or frame_start.
module rgb_frame_writer #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 10,
    parameter int FRAME_PIXELS = 500
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     out_valid,
    input  logic [23:0]              rgb_in,
    input  logic                     mem_ready,
    output logic                     mem_wen,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [23:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     frame_done,
    output logic                     overflow
`ifdef CHECKSUM_EN
    ,
    output logic [23:0]              checksum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [23:0]         fifo_q [DEPTH];
    logic [23:0]         fifo_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                xfer_s;
    logic                pop_s;
    logic                push_s;
    logic                full_s;
    logic                not_empty_s;

    // A transfer is an edge where the held request meets memory ready.
    assign xfer_s      = wen_q & mem_ready;
    assign full_s      = (level_q == FULL_LVL);
    assign not_empty_s = (level_q != {LVL_W{1'b0}});

    // Next-state logic: FSM, FIFO push/pop bookkeeping and frame_start override.
    always_comb begin
        state_d  = state_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        pop_s    = 1'b0;
        push_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (not_empty_s) begin
                    pop_s   = 1'b1;
                    wen_d   = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (xfer_s) begin
                    if (addr_q == LAST_ADDR) begin
                        wen_d   = 1'b0;
                        addr_d  = {ADDR_W{1'b0}};
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (not_empty_s) begin
                        // Back-to-back: reload the output register on the accepting edge.
                        pop_s   = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                    end else begin
                        wen_d   = 1'b0;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                // Frame complete: keep buffering, wait for frame_start.
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop_s) begin
            wdata_d  = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A full FIFO still accepts a word if it frees a slot on the same edge.
        push_s = out_valid & (~full_s | pop_s);
        if (out_valid & ~push_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        if (push_s) begin
            fifo_d[wr_ptr_q] = rgb_in;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        level_d = level_q + LVL_W'(push_s) - LVL_W'(pop_s);

        // frame_start flushes everything; a word arriving on the same edge
        // becomes the first word of the new frame.
        if (frame_start) begin
            state_d  = ST_IDLE;
            addr_d   = {ADDR_W{1'b0}};
            ovf_d    = 1'b0;
            done_d   = 1'b0;
            wen_d    = 1'b0;
            rd_ptr_d = {PTR_W{1'b0}};
            if (out_valid) begin
                fifo_d[{PTR_W{1'b0}}] = rgb_in;
                wr_ptr_d = PTR_W'(1);
                level_d  = LVL_W'(1);
            end else begin
                wr_ptr_d = {PTR_W{1'b0}};
                level_d  = {LVL_W{1'b0}};
            end
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fifo_q   <= '{default: 24'h000000};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            wen_q    <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= 24'h000000;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mem_wen    = wen_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign fifo_level = level_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;

`ifdef CHECKSUM_EN
    logic [23:0] csum_q, csum_d;

    // XOR-accumulate every accepted write; frame_start restarts the sum.
    always_comb begin
        if (frame_start) begin
            csum_d = 24'h000000;
        end else if (xfer_s) begin
            csum_d = csum_q ^ wdata_q;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 24'h000000;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Bench for rgb_frame_writer (DEPTH=8, FRAME_PIXELS=10): a per-cycle vector
// table checks level/flags, a scoreboard checks every memory write.
module tb_rgb_frame_writer;

    localparam int DEPTH        = 8;
    localparam int ADDR_W       = 10;
    localparam int FRAME_PIXELS = 10;

    logic               clk;
    logic               reset;
    logic               frame_start;
    logic               out_valid;
    logic [23:0]        rgb_in;
    logic               mem_ready;
    logic               mem_wen;
    logic [ADDR_W-1:0]  mem_addr;
    logic [23:0]        mem_wdata;
    logic [3:0]         fifo_level;
    logic               frame_done;
    logic               overflow;
`ifdef CHECKSUM_EN
    logic [23:0]        checksum;
    logic [23:0]        csum_m;
`endif

    rgb_frame_writer #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .rgb_in      (rgb_in),
        .mem_ready   (mem_ready),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .fifo_level  (fifo_level),
        .frame_done  (frame_done),
        .overflow    (overflow)
`ifdef CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    typedef struct {
        logic        fs;
        logic        vld;
        logic [23:0] d;
        logic        rdy;
        logic        wr;     // word will reach memory in the current frame
        int          lvl;
        logic        wen;
        logic        ovf;
        logic        fd;
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   sb_addr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic fs, input logic vld, input logic [23:0] d, input logic rdy,
                       input logic wr, input int lvl, input logic wen, input logic ovf,
                       input logic fd);
        vec_t v;
        v.fs = fs; v.vld = vld; v.d = d; v.rdy = rdy; v.wr = wr;
        v.lvl = lvl; v.wen = wen; v.ovf = ovf; v.fd = fd;
        vecs.push_back(v);
    endtask

    // Scoreboard: every transfer must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_wen && mem_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
`ifdef CHECKSUM_EN
                csum_m = csum_m ^ e.data;
`endif
            end
        end
`ifdef CHECKSUM_EN
        if (frame_start) csum_m = 24'h000000;
`endif
    end

    initial begin
        logic [23:0] pat [4];
`ifdef CHECKSUM_EN
        csum_m = 24'h000000;
`endif
        pat[0] = 24'h112233; pat[1] = 24'h445566; pat[2] = 24'h778899; pat[3] = 24'hAABBCC;

        // Stall fill: 9 words buffered, same-edge pop+push at full, then a drop.
        for (int i = 0; i < 9; i++)
            add(1'b0, 1'b1, 24'(i + 1), 1'b0, 1'b1, (i == 0) ? 1 : i, (i >= 1), 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h00000A, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h00000B, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++)
            add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 7 - j, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);   // last pixel
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        // New frame, back-to-back streaming at full rate.
        add(1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++)
            add(1'b0, 1'b1, (k < 4) ? pat[k] : 24'h100000 + 24'(k), 1'b1, 1'b1, 1, (k >= 1),
                1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // DONE buffers but never pops; frame_start then flushes it.
        add(1'b0, 1'b1, 24'h5A5A5A, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // Three of five transferred, then abandoned by frame_start under stall.
        for (int m = 0; m < 5; m++)
            add(1'b0, 1'b1, 24'h0C0001 + 24'(m), 1'b1, (m < 3), 1, (m >= 1), 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 24'h0D0D0D, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0); // kept, goes to addr 0
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        reset = 1'b1; frame_start = 1'b0; out_valid = 1'b0; rgb_in = 24'h0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            frame_start = vecs[i].fs;
            out_valid   = vecs[i].vld;
            rgb_in      = vecs[i].d;
            mem_ready   = vecs[i].rdy;
            if (vecs[i].fs) sb_addr = 0;
            if (vecs[i].wr) begin
                sb_q.push_back({ADDR_W'(sb_addr), vecs[i].d});
                sb_addr = (sb_addr + 1) % FRAME_PIXELS;
            end
            @(posedge clk);
            #1;
            check($sformatf("level[%0d]", i), 32'(fifo_level), 32'(vecs[i].lvl));
            check($sformatf("wen[%0d]", i), 32'(mem_wen), 32'(vecs[i].wen));
            check($sformatf("ovf[%0d]", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("fd[%0d]", i), 32'(frame_done), 32'(vecs[i].fd));
`ifdef CHECKSUM_EN
            if (vecs[i].fd) check($sformatf("csum[%0d]", i), 32'(checksum), 32'(csum_m));
            if (vecs[i].fs) check($sformatf("csum_clr[%0d]", i), 32'(checksum), 32'd0);
`endif
        end
        frame_start = 1'b0;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // Mid-stream asynchronous reset with a full FIFO and overflow set.
        out_valid = 1'b1; mem_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            rgb_in = 24'h0E0000 + 24'(n);
            @(posedge clk);
            #1;
        end
        check("pre_rst_level", 32'(fifo_level), 32'd8);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_wen", 32'(mem_wen), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", 32'(mem_wdata), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_fd", 32'(frame_done), 32'd0);
`ifdef CHECKSUM_EN
        check("arst_csum", 32'(checksum), 32'd0);
`endif
        out_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_wen", 32'(mem_wen), 32'd0);
        check("post_rst_ovf", 32'(overflow), 32'd0);
        check("post_rst_wdata", 32'(mem_wdata), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
